// File: rtl/uart_module_onchip_ram_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slave ports, pipelined reads and address-error reporting.
// Optional per-byte even parity storage and checking is enabled with `define ONCHIP_RAM_PARITY_EN.
module uart_module_onchip_ram_dp #(
   parameter int    DATA_WIDTH   = 32,
   parameter int    DEPTH        = 17408,
   parameter int    ADDR_WIDTH   = 15,
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = "uart_module_onchip_memory2.hex"
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clken,
   input  logic                    reset_req,
   input  logic [ADDR_WIDTH-1:0]   a_address,
   input  logic                    a_chipselect,
   input  logic                    a_read,
   input  logic                    a_write,
   input  logic [DATA_WIDTH/8-1:0] a_byteenable,
   input  logic [DATA_WIDTH-1:0]   a_writedata,
   output logic [DATA_WIDTH-1:0]   a_readdata,
   output logic                    a_readdatavalid,
   output logic                    a_addr_err,
   output logic                    a_parity_err,
   input  logic [ADDR_WIDTH-1:0]   b_address,
   input  logic                    b_chipselect,
   input  logic                    b_read,
   input  logic                    b_write,
   input  logic [DATA_WIDTH/8-1:0] b_byteenable,
   input  logic [DATA_WIDTH-1:0]   b_writedata,
   output logic [DATA_WIDTH-1:0]   b_readdata,
   output logic                    b_readdatavalid,
   output logic                    b_addr_err,
   output logic                    b_parity_err
);
   localparam int NB = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

   generate
      if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
         $error("READ_LATENCY must be 1 or 2");
      end
      if (DATA_WIDTH % 8 != 0) begin : g_bad_width
         $error("DATA_WIDTH must be a multiple of 8");
      end
      if ((64'd1 << ADDR_WIDTH) < 64'(DEPTH)) begin : g_bad_depth
         $error("ADDR_WIDTH too small for DEPTH");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   // Port 0 is A, port 1 is B.
   logic                  en;
   logic [ADDR_WIDTH-1:0] addr [2];
   logic [NB-1:0]         be   [2];
   logic [DATA_WIDTH-1:0] wd   [2];
   logic [DATA_WIDTH-1:0] rraw [2];
   logic [1:0]            cs, rd, wr, rd_acc, wr_acc, in_range;

   logic [DATA_WIDTH-1:0] s1_d  [2];
   logic [DATA_WIDTH-1:0] out_d [2];
   logic [1:0]            s1_v, s1_e, wr_err, out_v, out_e, out_p;

   assign en      = clken & ~reset_req;
   assign addr[0] = a_address;
   assign addr[1] = b_address;
   assign be[0]   = a_byteenable;
   assign be[1]   = b_byteenable;
   assign wd[0]   = a_writedata;
   assign wd[1]   = b_writedata;
   assign cs      = {b_chipselect, a_chipselect};
   assign rd      = {b_read, a_read};
   assign wr      = {b_write, a_write};

   // A write on a port suppresses its read; out-of-range reads return zero.
   always_comb begin
      rd_acc   = '0;
      wr_acc   = '0;
      in_range = '0;
      for (int p = 0; p < 2; p++) begin
         in_range[p] = ({1'b0, addr[p]} < DEPTH_L);
         wr_acc[p]   = en & cs[p] & wr[p];
         rd_acc[p]   = en & cs[p] & rd[p] & ~wr[p];
         rraw[p]     = in_range[p] ? mem[addr[p]] : '0;
      end
   end

`ifdef ONCHIP_RAM_PARITY_EN
   logic [NB-1:0] par_mem [0:DEPTH-1];
   logic [1:0]    pbad, s1_p;

   function automatic logic [NB-1:0] lane_par(input logic [DATA_WIDTH-1:0] d);
      for (int l = 0; l < NB; l++) lane_par[l] = ^d[l*8 +: 8];
   endfunction

   always_comb begin
      pbad = '0;
      for (int p = 0; p < 2; p++)
         pbad[p] = in_range[p] && (lane_par(rraw[p]) != par_mem[addr[p]]);
   end
`endif

   // Port B is applied first so port A's lanes override it on a shared address.
   always_ff @(posedge clk) begin
      for (int p = 1; p >= 0; p--) begin
         if (wr_acc[p] && in_range[p]) begin
            for (int l = 0; l < NB; l++) begin
               if (be[p][l]) begin
                  mem[addr[p]][l*8 +: 8] <= wd[p][l*8 +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
                  par_mem[addr[p]][l] <= ^wd[p][l*8 +: 8];
`endif
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_v   <= '0;
         s1_e   <= '0;
         wr_err <= '0;
         s1_d[0] <= '0;
         s1_d[1] <= '0;
`ifdef ONCHIP_RAM_PARITY_EN
         s1_p   <= '0;
`endif
      end else if (en) begin
         s1_v   <= rd_acc;
         s1_e   <= rd_acc & ~in_range;
         wr_err <= wr_acc & ~in_range;
`ifdef ONCHIP_RAM_PARITY_EN
         s1_p   <= rd_acc & pbad;
`endif
         for (int p = 0; p < 2; p++)
            if (rd_acc[p]) s1_d[p] <= rraw[p];
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               out_v    <= '0;
               out_e    <= '0;
               out_p    <= '0;
               out_d[0] <= '0;
               out_d[1] <= '0;
            end else if (en) begin
               out_v <= s1_v;
               out_e <= s1_e;
`ifdef ONCHIP_RAM_PARITY_EN
               out_p <= s1_p;
`else
               out_p <= '0;
`endif
               for (int p = 0; p < 2; p++)
                  if (s1_v[p]) out_d[p] <= s1_d[p];
            end
         end
      end else begin : g_lat1
         assign out_v = s1_v;
         assign out_e = s1_e;
         assign out_d = s1_d;
`ifdef ONCHIP_RAM_PARITY_EN
         assign out_p = s1_p;
`else
         assign out_p = '0;
`endif
      end
   endgenerate

   assign a_readdata      = out_d[0];
   assign b_readdata      = out_d[1];
   assign a_readdatavalid = out_v[0];
   assign b_readdatavalid = out_v[1];
   assign a_addr_err      = out_e[0] | wr_err[0];
   assign b_addr_err      = out_e[1] | wr_err[1];
   assign a_parity_err    = out_p[0];
   assign b_parity_err    = out_p[1];
endmodule

// File: tb/tb_uart_module_onchip_ram_dp.sv
// Directed bench for uart_module_onchip_ram_dp; dut uses READ_LATENCY=1, dut2 READ_LATENCY=2 on shared stimulus.
module tb_uart_module_onchip_ram_dp;
   logic        clk = 1'b0;
   logic        reset, clken, reset_req;
   logic [14:0] a_address, b_address;
   logic        a_chipselect, a_read, a_write, b_chipselect, b_read, b_write;
   logic [3:0]  a_byteenable, b_byteenable;
   logic [31:0] a_writedata, b_writedata;
   logic [31:0] a_readdata, b_readdata, a2_readdata, b2_readdata;
   logic        a_readdatavalid, b_readdatavalid, a_addr_err, b_addr_err, a_parity_err, b_parity_err;
   logic        a2_readdatavalid, b2_readdatavalid, a2_addr_err, b2_addr_err, a2_parity_err, b2_parity_err;

   int          errors = 0;
   int          checks = 0;
   int          idx, nval;
   logic        en_c, rd_now;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   uart_module_onchip_ram_dp #(.READ_LATENCY(1), .INIT_FILE("")) dut (
      .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
      .a_address(a_address), .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write),
      .a_byteenable(a_byteenable), .a_writedata(a_writedata), .a_readdata(a_readdata),
      .a_readdatavalid(a_readdatavalid), .a_addr_err(a_addr_err), .a_parity_err(a_parity_err),
      .b_address(b_address), .b_chipselect(b_chipselect), .b_read(b_read), .b_write(b_write),
      .b_byteenable(b_byteenable), .b_writedata(b_writedata), .b_readdata(b_readdata),
      .b_readdatavalid(b_readdatavalid), .b_addr_err(b_addr_err), .b_parity_err(b_parity_err)
   );

   uart_module_onchip_ram_dp #(.READ_LATENCY(2), .INIT_FILE("")) dut2 (
      .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
      .a_address(a_address), .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write),
      .a_byteenable(a_byteenable), .a_writedata(a_writedata), .a_readdata(a2_readdata),
      .a_readdatavalid(a2_readdatavalid), .a_addr_err(a2_addr_err), .a_parity_err(a2_parity_err),
      .b_address(b_address), .b_chipselect(b_chipselect), .b_read(b_read), .b_write(b_write),
      .b_byteenable(b_byteenable), .b_writedata(b_writedata), .b_readdata(b2_readdata),
      .b_readdatavalid(b2_readdatavalid), .b_addr_err(b2_addr_err), .b_parity_err(b2_parity_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_chipselect = 1'b0; a_read = 1'b0; a_write = 1'b0;
      b_chipselect = 1'b0; b_read = 1'b0; b_write = 1'b0;
   endtask

   task automatic a_wr(input logic [14:0] ad, input logic [31:0] d, input logic [3:0] be);
      a_chipselect = 1'b1; a_write = 1'b1; a_read = 1'b0;
      a_address = ad; a_writedata = d; a_byteenable = be;
   endtask

   task automatic a_rd(input logic [14:0] ad);
      a_chipselect = 1'b1; a_write = 1'b0; a_read = 1'b1; a_address = ad;
   endtask

   task automatic b_wr(input logic [14:0] ad, input logic [31:0] d, input logic [3:0] be);
      b_chipselect = 1'b1; b_write = 1'b1; b_read = 1'b0;
      b_address = ad; b_writedata = d; b_byteenable = be;
   endtask

   task automatic b_rd(input logic [14:0] ad);
      b_chipselect = 1'b1; b_write = 1'b0; b_read = 1'b1; b_address = ad;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
      a_address = '0; b_address = '0; a_byteenable = '0; b_byteenable = '0;
      a_writedata = '0; b_writedata = '0;
      idle();
      step(); step();
      chk("rst_a_data", a_readdata, 32'h0);
      chk("rst_a_valid", a_readdatavalid, 32'h0);
      chk("rst_b_addr_err", b_addr_err, 32'h0);
      chk("rst_a_parity", a_parity_err, 32'h0);
      reset = 1'b0;
      step();

      // Basic write then read on both latencies.
      a_wr(15'h10, 32'hDEADBEEF, 4'hF); step(); idle();
      a_rd(15'h10); step(); idle();
      chk("lat1_valid", a_readdatavalid, 32'h1);
      chk("lat1_data", a_readdata, 32'hDEADBEEF);
      chk("lat2_early", a2_readdatavalid, 32'h0);
      step();
      chk("lat1_pulse", a_readdatavalid, 32'h0);
      chk("lat1_hold", a_readdata, 32'hDEADBEEF);
      chk("lat2_valid", a2_readdatavalid, 32'h1);
      chk("lat2_data", a2_readdata, 32'hDEADBEEF);
      step();

      // Byte-lane merge across ports.
      a_wr(15'h20, 32'h11223344, 4'hF); step(); idle();
      b_wr(15'h20, 32'hAABBCCDD, 4'b0101); step(); idle();
      b_rd(15'h20); step(); idle();
      chk("merge_valid", b_readdatavalid, 32'h1);
      chk("merge_data", b_readdata, 32'h11BB33DD);

      // Simultaneous writes: A wins on lane 2, B keeps lane 1, lane 0 untouched.
      a_wr(15'h30, 32'h0, 4'hF); step(); idle();
      a_wr(15'h30, 32'hFFFF0000, 4'b1100); b_wr(15'h30, 32'h12345678, 4'b0110); step(); idle();
      a_rd(15'h30); step(); idle();
      chk("collide_data", a_readdata, 32'hFFFF5600);

      // Cross-port read during write returns old data.
      a_wr(15'h30, 32'h0, 4'hF); b_rd(15'h30); step(); idle();
      chk("xrdw_data", b_readdata, 32'hFFFF5600);
      a_rd(15'h30); step(); idle();
      chk("xrdw_new", a_readdata, 32'h0);

      // Read and write together: write wins, no valid.
      a_wr(15'h50, 32'h12345678, 4'hF); a_read = 1'b1; step(); idle();
      chk("rw_no_valid", a_readdatavalid, 32'h0);
      a_rd(15'h50); step(); idle();
      chk("rw_written", a_readdata, 32'h12345678);

      // Zero byteenable is a no-op write.
      a_wr(15'h50, 32'hFFFFFFFF, 4'h0); step(); idle();
      a_rd(15'h50); step(); idle();
      chk("be0_noop", a_readdata, 32'h12345678);

      // Stalls drop requests.
      step();
      reset_req = 1'b1; a_rd(15'h10); step(); idle(); reset_req = 1'b0;
      chk("rreq_no_valid", a_readdatavalid, 32'h0);
      step();
      chk("rreq_dropped", a_readdatavalid, 32'h0);
      clken = 1'b0; a_wr(15'h10, 32'h0, 4'hF); step(); idle(); clken = 1'b1;
      a_rd(15'h10); step(); idle();
      chk("stall_wr_drop", a_readdata, 32'hDEADBEEF);

      // Back-to-back reads with a 3-cycle clken stall.
      for (int i = 0; i < 8; i++) begin
         a_wr(15'(i), 32'hC0DE0000 + i, 4'hF); step();
         exp_q.push_back(32'hC0DE0000 + i);
      end
      idle();
      idx = 0; nval = 0;
      for (int c = 0; c < 14; c++) begin
         en_c   = !(c >= 4 && c <= 6);
         rd_now = (idx < 8);
         clken  = en_c;
         if (rd_now) a_rd(15'(idx)); else idle();
         step();
         if (en_c) begin
            if (rd_now) idx++;
            chk("stall_valid", a_readdatavalid, 32'(rd_now));
            if (a_readdatavalid) begin
               nval++;
               if (exp_q.size() > 0) chk("stall_data", a_readdata, exp_q.pop_front());
               else chk("stall_extra", a_readdatavalid, 32'h0);
            end
         end else begin
            chk("hold_valid", a_readdatavalid, 32'h1);
            chk("hold_data", a_readdata, 32'hC0DE0003);
         end
      end
      idle(); clken = 1'b1;
      chk("stall_count", nval, 32'd8);
      chk("stall_queue", exp_q.size(), 32'd0);

      // Out-of-range accesses.
      b_wr(15'h0400, 32'h600DF00D, 4'hF); step(); idle();
      b_rd(15'd17408); step(); idle();
      chk("oor_rd_valid", b_readdatavalid, 32'h1);
      chk("oor_rd_data", b_readdata, 32'h0);
      chk("oor_rd_err", b_addr_err, 32'h1);
      chk("oor_rd_parity", b_parity_err, 32'h0);
      step();
      chk("oor_err_pulse", b_addr_err, 32'h0);
      b_wr(15'd17408, 32'h55555555, 4'hF); step(); idle();
      chk("oor_wr_err", b_addr_err, 32'h1);
      chk("oor_wr_novalid", b_readdatavalid, 32'h0);
      b_rd(15'h0400); step(); idle();
      chk("oor_wr_alias", b_readdata, 32'h600DF00D);
      chk("oor_ok_err", b_addr_err, 32'h0);
      b_rd(15'h0); step(); idle();
      chk("oor_wr_word0", b_readdata, 32'hC0DE0000);

      // Parity with a corrupted stored bit.
      a_wr(15'h40, 32'h000000FF, 4'hF); step(); idle();
`ifdef ONCHIP_RAM_PARITY_EN
      dut.mem[64] = dut.mem[64] ^ 32'h1;
`endif
      a_rd(15'h40); step(); idle();
      chk("par_valid", a_readdatavalid, 32'h1);
`ifdef ONCHIP_RAM_PARITY_EN
      chk("par_err", a_parity_err, 32'h1);
      chk("par_data", a_readdata, 32'h000000FE);
`else
      chk("par_err", a_parity_err, 32'h0);
      chk("par_data", a_readdata, 32'h000000FF);
`endif

      // Reset in the middle of reads discards them.
      step();
      a_rd(15'h10); step(); idle();
      reset = 1'b1;
      #1;
      chk("rst_mid_valid1", a_readdatavalid, 32'h0);
      chk("rst_mid_data1", a_readdata, 32'h0);
      step();
      chk("rst_mid_valid2", a2_readdatavalid, 32'h0);
      reset = 1'b0;
      step();
      chk("rst_mid_valid2b", a2_readdatavalid, 32'h0);
      chk("rst_mid_data2", a2_readdata, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
